// File: rtl/pwm_peripheral.sv
// 16-channel PWM peripheral: shared prescaler, 8-bit period counter and duty compare.
// Define PWM_DUTY_SHADOW_EN to double-buffer the duty so it only changes at period wrap.
module pwm_peripheral #(
    parameter int unsigned PRESCALE_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE_DIV - 1);

    logic [15:0] presc_cnt;
    logic [7:0]  pwm_cnt;
    logic [7:0]  duty_active;
    logic        tick;
    logic        wrap;
    logic        pwm_high;
    logic [15:0] en_out;
    logic [15:0] en_pwm;

    assign tick   = (presc_cnt == PRESC_MAX);
    assign wrap   = tick && (pwm_cnt == 8'hFF);
    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= 16'd0;
        end else if (tick) begin
            presc_cnt <= 16'd0;
        end else begin
            presc_cnt <= presc_cnt + 16'd1;
        end
    end

    // pwm_cnt wraps 255 -> 0 by natural 8-bit overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt      <= 8'd0;
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
        end
    end

`ifdef PWM_DUTY_SHADOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_active <= 8'd0;
        end else if (wrap) begin
            duty_active <= pwm_duty_cycle;
        end
    end
`else
    assign duty_active = pwm_duty_cycle;
`endif

    // 0xFF is forced high so full duty has no one-count low gap at the wrap.
    assign pwm_high = (duty_active == 8'hFF) || (pwm_cnt < duty_active);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= 16'h0000;
        end else begin
            out <= en_out & (~en_pwm | {16{pwm_high}});
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: two instances (prescale 13 and 1) checked every
// clk against a time-based reference model, plus table vectors and corner-case sequences.
module tb_pwm_peripheral;

    localparam int PA = 13;
    localparam int PB = 1;
`ifdef PWM_DUTY_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  en_reg_out_7_0 = 8'h00;
    logic [7:0]  en_reg_out_15_8 = 8'h00;
    logic [7:0]  en_reg_pwm_7_0 = 8'h00;
    logic [7:0]  en_reg_pwm_15_8 = 8'h00;
    logic [7:0]  pwm_duty_cycle = 8'h00;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic        ps_a;
    logic        ps_b;

    int checks = 0;
    int errors = 0;
    int n = 0;
    logic [7:0] lat_a = 8'h00;
    logic [7:0] lat_b = 8'h00;

    always #5 clk = ~clk;

    pwm_peripheral #(.PRESCALE_DIV(PA)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .out(out_a), .period_start(ps_a)
    );

    pwm_peripheral #(.PRESCALE_DIV(PB)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .out(out_b), .period_start(ps_b)
    );

    typedef struct {
        logic [15:0] en_out;
        logic [15:0] en_pwm;
        logic [7:0]  duty;
        logic [15:0] expected;
    } vec_t;

    // Output after the n-th edge since release: high for the first duty*p clks of each period.
    function automatic logic [15:0] model_out(input int edge_n, input int p, input logic [15:0] eo,
                                              input logic [15:0] ep, input logic [7:0] duty);
        int   pos;
        logic high;
        pos  = (edge_n - 1) % (256 * p);
        high = (duty == 8'hFF) || (pos < int'(duty) * p);
        return eo & (~ep | {16{high}});
    endfunction

    task automatic apply_stimulus(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        {en_reg_out_15_8, en_reg_out_7_0} = eo;
        {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
        pwm_duty_cycle = d;
    endtask

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n);
        end
    endtask

    // One clk: model the edge from the inputs held before it, then compare both instances.
    task automatic step();
        logic [15:0] eo;
        logic [15:0] ep;
        logic [7:0]  d;
        logic [7:0]  da;
        logic [7:0]  db;
        eo = {en_reg_out_15_8, en_reg_out_7_0};
        ep = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        d  = pwm_duty_cycle;
        @(posedge clk);
        if (rst_n) n++;
        #1;
        if (!rst_n) begin
            check_output("reset_out_a", out_a, 16'h0000);
            check_output("reset_ps_a", {15'b0, ps_a}, 16'h0000);
            check_output("reset_out_b", out_b, 16'h0000);
            check_output("reset_ps_b", {15'b0, ps_b}, 16'h0000);
        end else begin
            da = SHADOW ? lat_a : d;
            db = SHADOW ? lat_b : d;
            check_output("model_out_a", out_a, model_out(n, PA, eo, ep, da));
            check_output("model_ps_a", {15'b0, ps_a}, {15'b0, (n % (256 * PA)) == 0});
            check_output("model_out_b", out_b, model_out(n, PB, eo, ep, db));
            check_output("model_ps_b", {15'b0, ps_b}, {15'b0, (n % (256 * PB)) == 0});
            if ((n % (256 * PA)) == 0) lat_a = d;
            if ((n % (256 * PB)) == 0) lat_b = d;
        end
    endtask

    task automatic wait_ps(input string name, output int waited);
        waited = 0;
        do begin
            step();
            waited++;
        end while (!ps_a && waited < 256 * PA + 16);
        if (!ps_a) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: period_start timeout after %0d clks, required within %0d",
                     name, waited, 256 * PA + 16);
        end
    endtask

    task automatic step_until_cnt(input string name, input int target);
        int k;
        k = 0;
        while (((n / PA) % 256) != target && k < 256 * PA + 16) begin
            step();
            k++;
        end
        if (((n / PA) % 256) != target) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: count %0d not reached, required %0d", name, (n / PA) % 256, target);
        end
    endtask

    task automatic run_window(input int cycles, input logic [15:0] pwm_mask, input logic [15:0] static_exp,
                              output int high0, output int ps_at, output int bad);
        high0 = 0;
        ps_at = -1;
        bad   = 0;
        for (int i = 1; i <= cycles; i++) begin
            step();
            if (out_a[0]) high0++;
            if (ps_a && ps_at < 0) ps_at = i;
            if ((out_a & pwm_mask) != 16'h0000 && (out_a & pwm_mask) != pwm_mask) bad++;
            if ((out_a & ~pwm_mask) != static_exp) bad++;
        end
    endtask

    initial begin
        vec_t vecs[$];
        int   high0;
        int   ps_at;
        int   bad;
        int   waited;

        vecs.push_back('{16'hFFFF, 16'h0000, 8'h00, 16'hFFFF});
        vecs.push_back('{16'h0000, 16'hFFFF, 8'hFF, 16'h0000});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 8'h00, 16'h0000});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 8'hFF, 16'hFFFF});
        vecs.push_back('{16'h00FF, 16'h0F0F, 8'h00, 16'h00F0});
        vecs.push_back('{16'h00FF, 16'h0F0F, 8'hFF, 16'h00FF});
        vecs.push_back('{16'hA5A5, 16'hFFFF, 8'hFF, 16'hA5A5});
        vecs.push_back('{16'hA5A5, 16'h00FF, 8'h00, 16'hA500});
        vecs.push_back('{16'h1234, 16'h0000, 8'hFF, 16'h1234});
        vecs.push_back('{16'hFFFF, 16'h5555, 8'h00, 16'hAAAA});

        $display("[TB] reset and static enables");
        for (int i = 0; i < 3; i++) step();
        check_output("reset_hold_out", out_a, 16'h0000);
        apply_stimulus(16'hFFFF, 16'h0000, 8'h00);
        rst_n = 1'b1;
        step();
        step();
        check_output("p1_static_on_second_clk", out_b, 16'hFFFF);
        check_output("p13_static_on_second_clk", out_a, 16'hFFFF);

        $display("[TB] table vectors");
        foreach (vecs[i]) begin
            if (SHADOW && vecs[i].duty != 8'h00) continue;
            apply_stimulus(vecs[i].en_out, vecs[i].en_pwm, vecs[i].duty);
            step();
            check_output($sformatf("table_vec_%0d", i), out_a, vecs[i].expected);
        end

        $display("[TB] duty 0x80 period and spacing");
        apply_stimulus(16'hFFFF, 16'hFFFF, 8'h80);
        wait_ps("wait_ps_80", waited);
        run_window(256 * PA, 16'hFFFF, 16'h0000, high0, ps_at, bad);
        check_output("duty80_high_clks", 16'(high0), 16'(128 * PA));
        check_output("period_spacing", 16'(ps_at), 16'(256 * PA));
        check_output("duty80_phase", 16'(bad), 16'd0);

        $display("[TB] duty 0x00 and 0xFF for three periods");
        apply_stimulus(16'hFFFF, 16'hFFFF, 8'h00);
        wait_ps("wait_ps_00", waited);
        run_window(3 * 256 * PA, 16'hFFFF, 16'h0000, high0, ps_at, bad);
        check_output("duty00_high_clks", 16'(high0), 16'd0);
        apply_stimulus(16'hFFFF, 16'hFFFF, 8'hFF);
        wait_ps("wait_ps_ff", waited);
        run_window(3 * 256 * PA, 16'hFFFF, 16'h0000, high0, ps_at, bad);
        check_output("dutyff_high_clks", 16'(high0), 16'(3 * 256 * PA));
        check_output("dutyff_phase", 16'(bad), 16'd0);

        $display("[TB] mid-period duty change");
        apply_stimulus(16'hFFFF, 16'hFFFF, 8'h40);
        wait_ps("wait_ps_40", waited);
        step_until_cnt("reach_cnt_60", 'h60);
        apply_stimulus(16'hFFFF, 16'hFFFF, 8'hC0);
        step();
        check_output("duty_change_next_clk", out_a, SHADOW ? 16'h0000 : 16'hFFFF);
        wait_ps("wait_ps_c0", waited);
        run_window(256 * PA, 16'hFFFF, 16'h0000, high0, ps_at, bad);
        check_output("dutyc0_high_clks", 16'(high0), 16'(192 * PA));

        $display("[TB] mixed enables");
        apply_stimulus(16'h00FF, 16'h0F0F, 8'h20);
        wait_ps("wait_ps_mixed", waited);
        run_window(256 * PA, 16'h000F, 16'h00F0, high0, ps_at, bad);
        check_output("mixed_high_clks", 16'(high0), 16'(32 * PA));
        check_output("mixed_static_and_phase", 16'(bad), 16'd0);

        $display("[TB] reset mid-period");
        step_until_cnt("reach_cnt_90", 'h90);
        #2;
        rst_n = 1'b0;
        n = 0;
        lat_a = 8'h00;
        lat_b = 8'h00;
        #1;
        check_output("async_reset_out_a", out_a, 16'h0000);
        check_output("async_reset_out_b", out_b, 16'h0000);
        step();
        step();
        rst_n = 1'b1;
        wait_ps("wait_ps_after_reset", waited);
        check_output("ps_after_release", 16'(waited), 16'(256 * PA));

        $display("[TB] randomized stimulus");
        for (int r = 0; r < 300; r++) begin
            logic [7:0] d;
            case ($urandom % 4)
                0:       d = 8'h00;
                1:       d = 8'hFF;
                default: d = 8'($urandom);
            endcase
            apply_stimulus(16'($urandom), 16'($urandom), d);
            for (int k = 0; k < int'($urandom_range(1, 20)); k++) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
